// File: rtl/gate_pkg.sv
// Shared encodings for the gate sweep checker: gate modes under test and FSM states.
package gate_pkg;

    typedef enum logic [2:0] {
        MODE_NAND = 3'd0,
        MODE_NOR  = 3'd1,
        MODE_AND  = 3'd2,
        MODE_OR   = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_ZERO = 3'd6,
        MODE_ONE  = 3'd7
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gate_golden.sv
// Combinational golden model: the expected gate output for a given mode and input vector.
module gate_golden
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      mode,
    input  logic [N_IN-1:0] stim,
    output logic            y
);

    always_comb begin
        y = 1'b0;
        case (mode)
            MODE_NAND: y = ~&stim;
            MODE_NOR:  y = ~|stim;
            MODE_AND:  y = &stim;
            MODE_OR:   y = |stim;
            MODE_XOR:  y = ^stim;
            MODE_XNOR: y = ~^stim;
            MODE_ZERO: y = 1'b0;
            MODE_ONE:  y = 1'b1;
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of an external gate: drives every input vector, waits
// SETTLE cycles, compares against the golden model and records errors.
module gate_sweep_checker
    import gate_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            dut_y,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
    localparam logic [N_IN-1:0] STIM_ONE   = N_IN'(1);
    localparam logic [N_IN-1:0] STIM_LAST  = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_ONE    = (N_IN + 1)'(1);

    state_t     state_q;
    state_t     state_d;
    mode_t      mode_q;
    logic [3:0] settle_cnt;
    logic       golden_y;
    logic       last_vec;
    logic       mismatch;

    gate_golden #(.N_IN(N_IN)) u_golden (
        .mode (mode_q),
        .stim (stim),
        .y    (golden_y)
    );

    assign last_vec = (stim == STIM_LAST);
    assign mismatch = (state_q == ST_CHECK) && (dut_y != golden_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // With SETTLE=0 the WAIT state is skipped entirely and each vector lasts one CHECK cycle.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    state_d = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (settle_cnt <= 4'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pass = done && (err_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q         <= MODE_NAND;
            stim           <= '0;
            settle_cnt     <= 4'd0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q         <= mode_t'(mode);
                        stim           <= '0;
                        settle_cnt     <= SETTLE_CNT;
                        err_cnt        <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + ERR_ONE;
                        if (!first_fail_vld) begin
                            first_fail     <= stim;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (!last_vec) begin
                        stim       <= stim + STIM_ONE;
                        settle_cnt <= SETTLE_CNT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: three checker instances (2/1, 3/0, 8/15) sweep a behavioural gate with
// optional planted faults; results are compared against a truth-table reference model.
module tb_gate_sweep_checker;

    localparam int N_ARR[3] = '{2, 3, 8};
    localparam int S_ARR[3] = '{1, 0, 15};

    logic         clk = 1'b0;
    logic         rst;
    logic         start_s [3];
    logic [2:0]   mode_s  [3];
    int           kind_s  [3];
    logic [255:0] flip_s  [3];

    logic [1:0] stim0;  logic [2:0] err0;  logic [1:0] ff0;
    logic [2:0] stim1;  logic [3:0] err1;  logic [2:0] ff1;
    logic [7:0] stim2;  logic [8:0] err2;  logic [7:0] ff2;
    logic busy0, done0, pass0, ffv0, y0;
    logic busy1, done1, pass1, ffv1, y1;
    logic busy2, done2, pass2, ffv2, y2;

    logic [7:0] stim_v [3];
    logic [8:0] err_v  [3];
    logic [7:0] ff_v   [3];
    logic       busy_v [3];
    logic       done_v [3];
    logic       pass_v [3];
    logic       ffv_v  [3];

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    // Truth tables expressed by counting ones rather than by reduction operators.
    function automatic logic ref_gate(input int m, input int v, input int n);
        int ones;
        int all_ones;
        ones = $countones(v);
        all_ones = (1 << n) - 1;
        case (m)
            0: return (v != all_ones);
            1: return (v == 0);
            2: return (v == all_ones);
            3: return (v != 0);
            4: return (ones % 2) == 1;
            5: return (ones % 2) == 0;
            6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign y0 = ref_gate(kind_s[0], int'(stim0), 2) ^ flip_s[0][stim0];
    assign y1 = ref_gate(kind_s[1], int'(stim1), 3) ^ flip_s[1][stim1];
    assign y2 = ref_gate(kind_s[2], int'(stim2), 8) ^ flip_s[2][stim2];

    gate_sweep_checker #(.N_IN(2), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]), .dut_y(y0),
        .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_fail(ff0), .first_fail_vld(ffv0)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]), .dut_y(y1),
        .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_fail(ff1), .first_fail_vld(ffv1)
    );

    gate_sweep_checker #(.N_IN(8), .SETTLE(15)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .mode(mode_s[2]), .dut_y(y2),
        .stim(stim2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_fail(ff2), .first_fail_vld(ffv2)
    );

    always_comb begin
        stim_v[0] = 8'(stim0); stim_v[1] = 8'(stim1); stim_v[2] = stim2;
        err_v[0]  = 9'(err0);  err_v[1]  = 9'(err1);  err_v[2]  = err2;
        ff_v[0]   = 8'(ff0);   ff_v[1]   = 8'(ff1);   ff_v[2]   = ff2;
        busy_v[0] = busy0;     busy_v[1] = busy1;     busy_v[2] = busy2;
        done_v[0] = done0;     done_v[1] = done1;     done_v[2] = done2;
        pass_v[0] = pass0;     pass_v[1] = pass1;     pass_v[2] = pass2;
        ffv_v[0]  = ffv0;      ffv_v[1]  = ffv1;      ffv_v[2]  = ffv2;
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input int id, input string tag);
        checkOutput($sformatf("%s_i%0d_stim", tag, id), int'(stim_v[id]), 0);
        checkOutput($sformatf("%s_i%0d_busy", tag, id), int'(busy_v[id]), 0);
        checkOutput($sformatf("%s_i%0d_done", tag, id), int'(done_v[id]), 0);
        checkOutput($sformatf("%s_i%0d_pass", tag, id), int'(pass_v[id]), 0);
        checkOutput($sformatf("%s_i%0d_err", tag, id), int'(err_v[id]), 0);
        checkOutput($sformatf("%s_i%0d_ff", tag, id), int'(ff_v[id]), 0);
        checkOutput($sformatf("%s_i%0d_ffv", tag, id), int'(ffv_v[id]), 0);
    endtask

    // One full sweep on instance id: checker mode m against a bench gate of kind 'kind'
    // with output inversions at the vectors set in 'flips'.
    task automatic applyStimulus(input int id, input int m, input int kind,
                                 input logic [255:0] flips, input bit disturb);
        int n, total, exp_len, errs, first_bad, cycles;
        n = N_ARR[id];
        total = 1 << n;
        exp_len = total * (S_ARR[id] + 1);
        errs = 0;
        first_bad = -1;
        for (int v = 0; v < total; v++) begin
            if ((ref_gate(kind, v, n) ^ flips[v]) != ref_gate(m, v, n)) begin
                errs++;
                if (first_bad < 0) first_bad = v;
            end
        end
        @(negedge clk);
        kind_s[id] = kind;
        flip_s[id] = flips;
        mode_s[id] = 3'(m);
        start_s[id] = 1'b1;
        @(posedge clk); #1;
        start_s[id] = 1'b0;
        checkOutput($sformatf("i%0d_m%0d_busy_at_accept", id, m), int'(busy_v[id]), 1);
        checkOutput($sformatf("i%0d_m%0d_done_at_accept", id, m), int'(done_v[id]), 0);
        checkOutput($sformatf("i%0d_m%0d_pass_while_busy", id, m), int'(pass_v[id]), 0);
        checkOutput($sformatf("i%0d_m%0d_stim_at_accept", id, m), int'(stim_v[id]), 0);
        checkOutput($sformatf("i%0d_m%0d_err_cleared", id, m), int'(err_v[id]), 0);
        checkOutput($sformatf("i%0d_m%0d_ffv_cleared", id, m), int'(ffv_v[id]), 0);
        cycles = 0;
        while (!done_v[id] && cycles < exp_len + 20) begin
            if (disturb && cycles == 1) begin
                start_s[id] = 1'b1;
                mode_s[id] = 3'($urandom_range(0, 7));
            end else if (disturb && cycles == 2) begin
                start_s[id] = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start_s[id] = 1'b0;
        checkOutput($sformatf("i%0d_m%0d_sweep_len", id, m), cycles, exp_len);
        checkOutput($sformatf("i%0d_m%0d_done", id, m), int'(done_v[id]), 1);
        checkOutput($sformatf("i%0d_m%0d_busy_end", id, m), int'(busy_v[id]), 0);
        checkOutput($sformatf("i%0d_m%0d_pass", id, m), int'(pass_v[id]), (errs == 0) ? 1 : 0);
        checkOutput($sformatf("i%0d_m%0d_err_cnt", id, m), int'(err_v[id]), errs);
        checkOutput($sformatf("i%0d_m%0d_ffv", id, m), int'(ffv_v[id]), (errs > 0) ? 1 : 0);
        if (errs > 0) begin
            checkOutput($sformatf("i%0d_m%0d_first_fail", id, m), int'(ff_v[id]), first_bad);
        end
        checkOutput($sformatf("i%0d_m%0d_stim_hold", id, m), int'(stim_v[id]), total - 1);
        @(posedge clk); #1;
        checkOutput($sformatf("i%0d_m%0d_done_held", id, m), int'(done_v[id]), 1);
    endtask

    initial begin
        logic [255:0] flips;
        int cycles;
        bit saw_done;
        int id, m, kind;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            mode_s[i] = 3'd0;
            kind_s[i] = 0;
            flip_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) checkAllZero(i, "reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed sweeps");
        applyStimulus(0, 0, 0, '0, 1'b0);
        applyStimulus(0, 0, 2, '0, 1'b0);
        flips = '0;
        flips[7] = 1'b1;
        applyStimulus(1, 4, 4, flips, 1'b0);
        applyStimulus(0, 3, 3, '0, 1'b1);
        applyStimulus(1, 5, 5, flips, 1'b1);

        $display("[TB] reset priority over start");
        @(negedge clk);
        start_s[0] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkAllZero(0, "rst_wins");
        start_s[0] = 1'b0;
        rst = 1'b0;

        $display("[TB] reset mid-sweep");
        @(negedge clk);
        kind_s[0] = 0;
        flip_s[0] = '0;
        mode_s[0] = 3'd0;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        cycles = 0;
        while (stim_v[0] != 8'd2 && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("abort_reach_stim2", int'(stim_v[0]), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkAllZero(0, "abort");
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_v[0]) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", int'(saw_done), 0);
        applyStimulus(0, 0, 0, '0, 1'b0);

        $display("[TB] randomized sweeps");
        for (int r = 0; r < 16; r++) begin
            id = int'($urandom_range(0, 1));
            m = int'($urandom_range(0, 7));
            kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : m;
            flips = '0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) flips[$urandom_range(0, (1 << N_ARR[id]) - 1)] = 1'b1;
            end
            applyStimulus(id, m, kind, flips, $urandom_range(0, 1) == 1);
        end

        $display("[TB] wide sweep");
        applyStimulus(2, 1, 1, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
